// File: rtl/tp_event_conditioner_pkg.sv
// tp_cond_pkg: shared definitions for the test-point event conditioner.
//   - tp_mode_e    : channel conditioning modes (pass / stretch / toggle / hold)
//   - trig_state_e : scope-trigger FSM state encoding
//   - TP_STRETCH_DEF / TP_HOLDOFF_DEF : default pulse-stretch and re-arm lockout
//   - sat_inc16    : saturating 16-bit increment used by the trigger counter
package tp_cond_pkg;

   typedef enum logic [1:0] {
      TPM_PASS    = 2'd0,
      TPM_STRETCH = 2'd1,
      TPM_TOGGLE  = 2'd2,
      TPM_HOLD    = 2'd3
   } tp_mode_e;

   typedef enum logic [1:0] {
      TRG_IDLE  = 2'd0,
      TRG_ARMED = 2'd1,
      TRG_FIRE  = 2'd2,
      TRG_HOLD  = 2'd3
   } trig_state_e;

   localparam int TP_STRETCH_DEF = 8;
   localparam int TP_HOLDOFF_DEF = 1024;

   // Increment that sticks at 0xFFFF instead of wrapping to zero.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/tp_event_conditioner_if.sv
// tp_event_conditioner_if: control/event bundle of the test-point event conditioner.
//   master (driver side): evt_in, mode_we, mode_din, clr, arm, trig_sel
//   slave  (conditioner): tp_out, trig_out, trig_armed, trig_cnt, mode
// NCH must match the NCH of the conditioner the bundle is attached to.
interface tp_event_conditioner_if #(
   parameter int NCH = 16
);
   logic [NCH-1:0] evt_in;
   logic           mode_we;
   logic [1:0]     mode_din;
   logic           clr;
   logic           arm;
   logic [3:0]     trig_sel;
   logic [NCH-1:0] tp_out;
   logic           trig_out;
   logic           trig_armed;
   logic [15:0]    trig_cnt;
   logic [1:0]     mode;

   modport master (
      output evt_in, mode_we, mode_din, clr, arm, trig_sel,
      input  tp_out, trig_out, trig_armed, trig_cnt, mode
   );

   modport slave (
      input  evt_in, mode_we, mode_din, clr, arm, trig_sel,
      output tp_out, trig_out, trig_armed, trig_cnt, mode
   );
endinterface

// File: rtl/tp_event_conditioner_chan.sv
// tp_chan: one event channel of the test-point conditioner.
//   clk, rst  : clock and synchronous active-high reset
//   mode      : current conditioning mode (shared register in the top level)
//   mode_we   : mode write strobe; clears all channel state on the same edge
//   clr       : clears the hold latch
//   evt_in    : raw event, synchronous to clk
//   rise      : rising edge of the delayed event (feeds the trigger mux)
//   tp_out    : registered, conditioned event for the test point
module tp_chan
   import tp_cond_pkg::*;
#(
   parameter int STRETCH = TP_STRETCH_DEF
) (
   input  logic     clk,
   input  logic     rst,
   input  tp_mode_e mode,
   input  logic     mode_we,
   input  logic     clr,
   input  logic     evt_in,
   output logic     rise,
   output logic     tp_out
);

   localparam int CW = $clog2(STRETCH + 1);

   logic          evt_d1_reg;
   logic          evt_d2_reg;
   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;
   logic          tog_reg;
   logic          tog_next;
   logic          hold_reg;
   logic          hold_next;
   logic          tp_reg;
   logic          tp_next;

   assign rise   = evt_d1_reg & ~evt_d2_reg;
   assign tp_out = tp_reg;

   always_comb begin
      cnt_next  = cnt_reg;
      tog_next  = tog_reg;
      hold_next = hold_reg;
      tp_next   = 1'b0;
      // The hold latch is cleared by clr whatever the mode; a rise in hold
      // mode below overrides it so the set wins.
      if (clr) begin
         hold_next = 1'b0;
      end
      case (mode)
         TPM_PASS: begin
            tp_next = evt_d1_reg;
         end
         TPM_STRETCH: begin
            if (rise) begin
               cnt_next = CW'(STRETCH);
            end else if (cnt_reg != '0) begin
               cnt_next = cnt_reg - CW'(1);
            end
            // cnt>1 (not >0) keeps the window at exactly STRETCH edges,
            // since the rise edge itself supplies the first high cycle.
            tp_next = rise | (cnt_reg > CW'(1));
         end
         TPM_TOGGLE: begin
            if (rise) begin
               tog_next = ~tog_reg;
            end
            tp_next = tog_next;
         end
         default: begin
            if (rise) begin
               hold_next = 1'b1;
            end
            tp_next = hold_next;
         end
      endcase
      // A mode write wipes channel state so the new mode starts clean;
      // the edge-detect pipeline is deliberately left running.
      if (mode_we) begin
         cnt_next  = '0;
         tog_next  = 1'b0;
         hold_next = 1'b0;
         tp_next   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evt_d1_reg <= 1'b0;
         evt_d2_reg <= 1'b0;
         cnt_reg    <= '0;
         tog_reg    <= 1'b0;
         hold_reg   <= 1'b0;
         tp_reg     <= 1'b0;
      end else begin
         evt_d1_reg <= evt_in;
         evt_d2_reg <= evt_d1_reg;
         cnt_reg    <= cnt_next;
         tog_reg    <= tog_next;
         hold_reg   <= hold_next;
         tp_reg     <= tp_next;
      end
   end

endmodule

// File: rtl/tp_event_conditioner.sv
// tp_event_conditioner: makes short internal debug strobes visible on test
// points (pass / stretch / toggle / hold per a shared mode register) and
// provides an armable one-shot scope trigger with holdoff.
//   clk, rst        : clock and synchronous active-high reset
//   bus (slave)     : evt_in, mode_we, mode_din, clr, arm, trig_sel in;
//                     tp_out, trig_out, trig_armed, trig_cnt, mode out
module tp_event_conditioner
   import tp_cond_pkg::*;
#(
   parameter int NCH     = 16,
   parameter int STRETCH = TP_STRETCH_DEF,
   parameter int HOLDOFF = TP_HOLDOFF_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   tp_event_conditioner_if.slave bus
);

   localparam int SW = $clog2(STRETCH + 1);
   localparam int HW = $clog2(HOLDOFF + 1);

   tp_mode_e      mode_reg;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] tp_out_w;
   logic [15:0]   rise_ext;
   logic          fire;

   trig_state_e   state_reg;
   logic [3:0]    sel_reg;
   logic [SW-1:0] fcnt_reg;
   logic [HW-1:0] hcnt_reg;
   logic [15:0]   trig_cnt_reg;
   logic          trig_out_reg;
   logic          trig_armed_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_reg <= TPM_STRETCH;
      end else if (bus.mode_we) begin
         mode_reg <= tp_mode_e'(bus.mode_din);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         tp_chan #(
            .STRETCH (STRETCH)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .mode    (mode_reg),
            .mode_we (bus.mode_we),
            .clr     (bus.clr),
            .evt_in  (bus.evt_in[gi]),
            .rise    (rise[gi]),
            .tp_out  (tp_out_w[gi])
         );
      end
   endgenerate

   // Zero-extended to 16 so any 4-bit select is a legal index; selects at or
   // above NCH land on constant zeros and the trigger simply never fires.
   assign rise_ext = 16'(rise);
   assign fire     = (state_reg == TRG_ARMED) && rise_ext[sel_reg];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= TRG_IDLE;
         sel_reg        <= '0;
         fcnt_reg       <= '0;
         hcnt_reg       <= '0;
         trig_out_reg   <= 1'b0;
         trig_armed_reg <= 1'b0;
      end else begin
         case (state_reg)
            TRG_IDLE: begin
               // Rises are not looked at here, so one coinciding with ARM is dropped.
               if (bus.arm) begin
                  sel_reg        <= bus.trig_sel;
                  state_reg      <= TRG_ARMED;
                  trig_armed_reg <= 1'b1;
               end
            end
            TRG_ARMED: begin
               if (fire) begin
                  state_reg      <= TRG_FIRE;
                  trig_out_reg   <= 1'b1;
                  trig_armed_reg <= 1'b0;
                  fcnt_reg       <= SW'(STRETCH);
               end
            end
            TRG_FIRE: begin
               if (fcnt_reg > SW'(1)) begin
                  fcnt_reg <= fcnt_reg - SW'(1);
               end else begin
                  state_reg    <= TRG_HOLD;
                  trig_out_reg <= 1'b0;
                  hcnt_reg     <= HW'(HOLDOFF);
               end
            end
            default: begin
               // Exactly HOLDOFF cycles in HOLD before ARM is listened to again.
               if (hcnt_reg > HW'(1)) begin
                  hcnt_reg <= hcnt_reg - HW'(1);
               end else begin
                  state_reg <= TRG_IDLE;
               end
            end
         endcase
      end
   end

   // clr has priority, so a clear coinciding with a firing leaves zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         trig_cnt_reg <= '0;
      end else if (bus.clr) begin
         trig_cnt_reg <= '0;
      end else if (fire) begin
         trig_cnt_reg <= sat_inc16(trig_cnt_reg);
      end
   end

   assign bus.tp_out     = tp_out_w;
   assign bus.trig_out   = trig_out_reg;
   assign bus.trig_armed = trig_armed_reg;
   assign bus.trig_cnt   = trig_cnt_reg;
   assign bus.mode       = mode_reg;

endmodule

// File: tb/tb_tp_event_conditioner.sv
// Bench for tp_event_conditioner (NCH=8, STRETCH=8, HOLDOFF=20): a vector
// table for the channel modes with a queue of expected outputs, followed by
// hand-written trigger, holdoff and reset sequences.
module tb_tp_event_conditioner;
   import tp_cond_pkg::*;

   localparam int NCH     = 8;
   localparam int STRETCH = 8;
   localparam int HOLDOFF = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tp_event_conditioner_if #(.NCH(NCH)) bus ();

   tp_event_conditioner #(
      .NCH     (NCH),
      .STRETCH (STRETCH),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [7:0] evt;
      logic       we;
      logic [1:0] din;
      logic       clr;
      logic [7:0] exp_tp;
      logic [1:0] exp_mode;
   } vec_t;

   typedef struct {
      logic [7:0] tp;
      logic [1:0] mode;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   function automatic vec_t mk(input logic [7:0] evt, input logic we, input logic [1:0] din,
                               input logic clr, input logic [7:0] tp, input logic [1:0] md);
      vec_t v;
      v.evt = evt; v.we = we; v.din = din; v.clr = clr; v.exp_tp = tp; v.exp_mode = md;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.evt_in = '0; bus.mode_we = 0; bus.mode_din = 0;
      bus.clr = 0; bus.arm = 0; bus.trig_sel = 0;

      // ---------------- reset state ----------------
      tick(); tick();
      chk("rst_tp", bus.tp_out, 0);
      chk("rst_trig_out", bus.trig_out, 0);
      chk("rst_armed", bus.trig_armed, 0);
      chk("rst_cnt", bus.trig_cnt, 0);
      chk("rst_mode", bus.mode, 1);
      rst = 0;

      // ---------------- saturating increment ----------------
      chk("sat_ffff", sat_inc16(16'hFFFF), 16'hFFFF);
      chk("sat_fffe", sat_inc16(16'hFFFE), 16'hFFFF);
      chk("sat_0010", sat_inc16(16'h0010), 16'h0011);

      // ---------------- channel-mode vector table ----------------
      // Stretch: single pulse on ch3 -> high on edges 1..8.
      for (int c = 0; c <= 10; c++)
         vecs.push_back(mk((c == 0) ? 8'h08 : 8'h00, 0, 0, 0,
                           (c >= 1 && c <= 8) ? 8'h08 : 8'h00, 2'd1));
      // Stretch: second pulse 5 cycles later -> 13 cycles total.
      for (int c = 0; c <= 15; c++)
         vecs.push_back(mk((c == 0 || c == 5) ? 8'h08 : 8'h00, 0, 0, 0,
                           (c >= 1 && c <= 13) ? 8'h08 : 8'h00, 2'd1));
      // Toggle on ch0, then switch to pass mid-sequence.
      vecs.push_back(mk(8'h00, 1, 2, 0, 8'h00, 2'd2));
      vecs.push_back(mk(8'h01, 0, 0, 0, 8'h00, 2'd2));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h01, 2'd2));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h01, 2'd2));
      vecs.push_back(mk(8'h01, 0, 0, 0, 8'h01, 2'd2));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 2'd2));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 2'd2));
      vecs.push_back(mk(8'h01, 0, 0, 0, 8'h00, 2'd2));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h01, 2'd2));
      vecs.push_back(mk(8'h00, 1, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(8'h01, 0, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(8'h01, 0, 0, 0, 8'h01, 2'd0));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h01, 2'd0));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 2'd0));
      // Hold on ch7: latch, CLR, CLR coincident with rise, second channel.
      vecs.push_back(mk(8'h00, 1, 3, 0, 8'h00, 2'd3));
      vecs.push_back(mk(8'h80, 0, 0, 0, 8'h00, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h80, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h80, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 1, 8'h00, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h00, 2'd3));
      vecs.push_back(mk(8'h80, 0, 0, 0, 8'h00, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 1, 8'h80, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h80, 2'd3));
      vecs.push_back(mk(8'h04, 0, 0, 0, 8'h80, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 0, 8'h84, 2'd3));
      vecs.push_back(mk(8'h00, 0, 0, 1, 8'h00, 2'd3));

      foreach (vecs[i]) begin
         exp_t e;
         bus.evt_in   = vecs[i].evt;
         bus.mode_we  = vecs[i].we;
         bus.mode_din = vecs[i].din;
         bus.clr      = vecs[i].clr;
         e.tp = vecs[i].exp_tp; e.mode = vecs[i].exp_mode;
         sb_q.push_back(e);
         tick();
         e = sb_q.pop_front();
         chk($sformatf("vec%0d_tp", i), bus.tp_out, e.tp);
         chk($sformatf("vec%0d_mode", i), bus.mode, e.mode);
      end
      bus.evt_in = 0; bus.mode_we = 0; bus.clr = 0;

      // ---------------- trigger ----------------
      // ARM coincident with a ch5 rise must not fire.
      bus.evt_in = 8'h20; tick();
      chk("armed_idle", bus.trig_armed, 0);
      bus.evt_in = 0; bus.arm = 1; bus.trig_sel = 4'd5; tick();
      chk("arm_accept", bus.trig_armed, 1);
      chk("arm_rise_nofire", bus.trig_out, 0);
      bus.arm = 0; tick();
      chk("arm_rise_nofire2", bus.trig_out, 0);
      chk("arm_rise_cnt", bus.trig_cnt, 0);
      // ARM while armed must not change the selected channel.
      bus.arm = 1; bus.trig_sel = 4'd3; tick(); bus.arm = 0;
      bus.evt_in = 8'h08; tick(); bus.evt_in = 0; tick();
      chk("ch3_nofire", bus.trig_out, 0);
      chk("ch3_still_armed", bus.trig_armed, 1);
      bus.evt_in = 8'h20; tick(); bus.evt_in = 0; tick();
      chk("fire_out", bus.trig_out, 1);
      chk("fire_disarm", bus.trig_armed, 0);
      chk("fire_cnt", bus.trig_cnt, 1);
      for (int i = 1; i < STRETCH; i++) begin
         bus.clr = (i == 3);
         tick();
         chk($sformatf("fire_hi%0d", i), bus.trig_out, 1);
         if (i == 3) chk("clr_cnt", bus.trig_cnt, 0);
      end
      bus.clr = 0; tick();
      chk("fire_len_end", bus.trig_out, 0);
      // Now in the first HOLD cycle; ARM is ignored throughout holdoff.
      bus.arm = 1; bus.trig_sel = 4'd5; tick();
      chk("arm_hold_first", bus.trig_armed, 0);
      bus.arm = 0;
      repeat (HOLDOFF - 2) tick();
      bus.arm = 1; tick();
      chk("arm_hold_last", bus.trig_armed, 0);
      tick();
      chk("rearm_earliest", bus.trig_armed, 1);
      bus.arm = 0;
      // CLR coincident with an increment leaves zero.
      bus.evt_in = 8'h20; tick(); bus.evt_in = 0; bus.clr = 1; tick();
      chk("fire2_out", bus.trig_out, 1);
      chk("clr_vs_inc", bus.trig_cnt, 0);
      bus.clr = 0; tick();
      chk("clr_vs_inc_hold", bus.trig_cnt, 0);
      repeat (STRETCH + HOLDOFF) tick();
      bus.arm = 1; bus.trig_sel = 4'd5; tick(); bus.arm = 0;
      bus.evt_in = 8'h20; tick(); bus.evt_in = 0; tick();
      chk("fire3_cnt", bus.trig_cnt, 1);
      repeat (STRETCH + HOLDOFF) tick();
      // Select beyond NCH never fires and stays armed.
      bus.arm = 1; bus.trig_sel = 4'd15; tick(); bus.arm = 0;
      chk("oob_armed", bus.trig_armed, 1);
      bus.evt_in = 8'hFF; tick(); bus.evt_in = 0;
      repeat (10) tick();
      chk("oob_nofire", bus.trig_out, 0);
      chk("oob_still_armed", bus.trig_armed, 1);
      chk("oob_cnt", bus.trig_cnt, 1);

      // ---------------- reset behaviour ----------------
      rst = 1; tick();
      chk("rst2_tp", bus.tp_out, 0);
      chk("rst2_armed", bus.trig_armed, 0);
      chk("rst2_cnt", bus.trig_cnt, 0);
      chk("rst2_mode", bus.mode, 1);
      rst = 0;
      bus.arm = 1; bus.trig_sel = 4'd1; tick(); bus.arm = 0;
      bus.evt_in = 8'h02; tick(); bus.evt_in = 0; tick();
      chk("mid_fire_out", bus.trig_out, 1);
      chk("mid_stretch_tp", bus.tp_out, 8'h02);
      tick(); tick();
      rst = 1; tick();
      chk("rst3_tp", bus.tp_out, 0);
      chk("rst3_trig_out", bus.trig_out, 0);
      chk("rst3_armed", bus.trig_armed, 0);
      chk("rst3_cnt", bus.trig_cnt, 0);
      chk("rst3_mode", bus.mode, 1);
      rst = 0; tick();
      chk("post_rst_tp", bus.tp_out, 0);
      chk("post_rst_trig_out", bus.trig_out, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tp_event_conditioner.md
# tp_event_conditioner

Conditions up to 16 short internal debug events (L1A, LCT, RESYNC, DSR_RST, EOS, etc.) so they can be seen on a scope, and feeds the test-point output stage. Single-cycle strobes cannot be seen reliably at test-point slew rates, so each channel is passed through, stretched, toggled or held, depending on a shared mode register. The block also produces an armable one-shot scope trigger, with holdoff, on a selected channel. Its outputs drive the test-point bank inputs directly.

## Interface
Parameters:
- NCH, 16, number of event channels (1..16)
- STRETCH, 8, stretch-mode high time in CLK cycles (>=1)
- HOLDOFF, 1024, trigger re-arm lockout in CLK cycles (>=1)

Ports:
- CLK  in  1  system clock; sole clock
- RST  in  1  synchronous, active-high reset
- EVT_IN  in  NCH  raw event inputs, synchronous to CLK
- MODE_WE  in  1  load strobe for MODE_DIN
- MODE_DIN  in  2  0=pass, 1=stretch, 2=toggle, 3=hold
- CLR  in  1  clears hold latches and TRIG_CNT
- ARM  in  1  arm trigger (single-cycle strobe)
- TRIG_SEL  in  4  trigger channel index; captured on ARM
- TP_OUT  out  NCH  conditioned events to the test points
- TRIG_OUT  out  1  scope trigger pulse
- TRIG_ARMED  out  1  high while armed
- TRIG_CNT  out  16  saturating count of trigger firings
- MODE  out  2  current mode

## Operation
- Input pipeline: evt_d1 <= EVT_IN; evt_d2 <= evt_d1; rise[i] = evt_d1[i] & ~evt_d2[i].
- Mode register:
  - Reset value 1 (stretch); loaded on MODE_WE.
  - A write clears all channel state (counters, toggle and hold flags, TP_OUT) on the same edge. Edge detection is not reset.
- Per-channel behaviour, all updates registered at the edge after rise:
  - pass: TP_OUT[i] <= evt_d1[i].
  - stretch: on rise, cnt <= STRETCH. Otherwise cnt decrements while nonzero. TP_OUT[i] <= (rise | cnt>1). The result is high for exactly STRETCH cycles after the latest rise, and the channel is retriggerable: a rise while high restarts the full window.
  - toggle: TP_OUT[i] flips on each rise.
  - hold: TP_OUT[i] is set on rise and cleared on CLR. If rise and CLR occur together, the set wins.
- Trigger FSM, states IDLE, ARMED, FIRE, HOLD:
  - IDLE: on ARM, latch sel <= TRIG_SEL and go to ARMED. A rise present in the ARM cycle is ignored.
  - ARMED: on rise[sel], go to FIRE and increment TRIG_CNT (saturates at 0xFFFF). ARM in this state is ignored and does not change sel.
  - FIRE: TRIG_OUT high for STRETCH cycles, then go to HOLD with hcnt <= HOLDOFF.
  - HOLD: ARM is ignored. When hcnt expires (HOLDOFF cycles), go to IDLE.
  - sel >= NCH: the trigger never fires. TRIG_ARMED stays high until RST.
  - TRIG_SEL selects the channel independently of the mode register.
- CLR clears TRIG_CNT. If CLR and an increment occur in the same cycle, the result is 0.
- RST: all outputs 0 except MODE=1. FSM goes to IDLE and the pipelines clear.

## Timing
- EVT_IN is first sampled high at edge k (evt_d1). TP_OUT responds at edge k+1 in every mode. Total latency is 2 CLK edges from input to output.
- Stretch: high on edges k+1 .. k+STRETCH, low at k+STRETCH+1 if there is no new rise.
- Trigger: the rise is detected in cycle k. FSM enters FIRE and TRIG_OUT goes high at edge k+1, for STRETCH cycles. TRIG_ARMED drops at edge k+1.
- The earliest re-arm is accepted STRETCH+HOLDOFF cycles after TRIG_OUT rises.
- A MODE_WE at edge m takes effect from edge m. The first output in the new mode appears at edge m+1.
- RST mid-stretch or mid-holdoff: outputs are 0 at the next edge, with no residual pulse.

## Structure
- Package tp_cond_pkg holds:
  - mode constants TPM_PASS/TPM_STRETCH/TPM_TOGGLE/TPM_HOLD
  - the trigger FSM state encoding
  - the default STRETCH/HOLDOFF values
- Sub-module tp_chan is one channel. It contains the edge detect, stretch counter, toggle and hold flags, and exposes its rise output for the trigger mux. It is instantiated NCH times.
- The trigger FSM and TRIG_CNT live in the top level.

## Test plan
- Stretch, STRETCH=8: a one-cycle pulse on EVT_IN[3] -> TP_OUT[3] high exactly 8 cycles, starting 2 edges after the input. A second pulse 5 cycles later -> total high time 13 cycles.
- Toggle: 3 pulses on EVT_IN[0] -> TP_OUT[0] goes 1, 0, 1. MODE_WE=pass mid-sequence -> TP_OUT[0] reads 0 at the write edge.
- Hold: pulse on EVT_IN[7] -> TP_OUT[7] latched 1. CLR -> 0. CLR coincident with a rise -> stays 1.
- Trigger: ARM with TRIG_SEL=5, then a pulse on ch5 -> TRIG_OUT high 8 cycles, TRIG_CNT=1. ARM during holdoff is ignored. ARM after STRETCH+HOLDOFF -> TRIG_ARMED=1.
- Edge cases:
  - ARM in the same cycle as a ch5 rise -> no fire.
  - TRIG_SEL=15 with NCH=8 -> never fires.
  - TRIG_CNT preloaded near 0xFFFF with repeated triggers -> saturates at 0xFFFF.
- RST asserted mid-stretch and in FIRE -> all outputs 0 and MODE=1 on the next edge.
